segbuf_rx: RTL and testbench

- Receive-side parser for the segmented data buffer, in the rx_clk domain downstream of the GTP receiver and inside the EVR.
- Consumes 16-bit 8b/10b-decoded words and extracts segment frames from the data byte: start K28.2, segment address, 16 data bytes, stop K28.1, 16-bit checksum.
- Verifies each frame and commits its payload as four 32-bit words to the shared-data memory write port.
- Reports frame status pulses and running statistics.

---
 rtl/segbuf_rx.sv | 177 +++++++++++++++++
 tb/tb_segbuf_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segbuf_rx.sv
// segbuf_rx: receive-side parser for the segmented data buffer. It extracts the
// frame K28.2 / segment / 16 data / K28.1 / csum and commits the verified payload as 4 words.
module segbuf_rx #(
  parameter bit          INTERLEAVED = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aligned,
  input  logic [15:0]      rx_data,
  input  logic [1:0]       rxcharisk,
  output logic             wr_en,
  output logic [9:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_STOP, S_CSUM_H, S_CSUM_L} state_t;

  localparam logic [7:0] K_START   = 8'h5C;
  localparam logic [7:0] K_STOP    = 8'h3C;
  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_CSUM    = 3'd1;
  localparam logic [2:0] E_STOP    = 3'd2;
  localparam logic [2:0] E_UNEXP_K = 3'd3;
  localparam logic [2:0] E_RESTART = 3'd4;
  localparam logic [2:0] E_ALIGN   = 3'd5;

  state_t      state;
  logic        phase;
  logic [3:0]  idx;
  logic [7:0]  seg;
  logic [15:0] sum;
  logic [7:0]  csum_hi;
  logic [7:0]  stage [16];
  logic [7:0]  cbuf  [16];
  logic [7:0]  cseg;
  logic [1:0]  c_word;
  logic        c_busy;

  logic [7:0]  byte_in;
  logic        is_k;
  logic        is_start;
  logic        slot;
  logic [2:0]  ev_err;
  logic        ev_ok;
  logic [3:0]  cb_base;
  logic [31:0] c_word_data;
  logic        unused_evt;

  assign byte_in    = rx_data[7:0];
  assign is_k       = rxcharisk[0];
  assign is_start   = is_k && (byte_in == K_START);
  assign slot       = !INTERLEAVED || phase;
  assign unused_evt = ^{rx_data[15:8], rxcharisk[1]};

  assign cb_base     = {c_word, 2'b00};
  assign c_word_data = {cbuf[cb_base], cbuf[cb_base + 4'd1], cbuf[cb_base + 4'd2], cbuf[cb_base + 4'd3]};

  // Per-clk frame verdict; at most one of ev_ok / ev_err can be raised
  always_comb begin
    ev_err = E_NONE;
    ev_ok  = 1'b0;
    if (state != S_IDLE) begin
      if (!aligned) begin
        ev_err = E_ALIGN;
      end else if (slot) begin
        if (is_start) begin
          ev_err = E_RESTART;
        end else begin
          case (state)
            S_STOP:   if (!(is_k && byte_in == K_STOP)) ev_err = E_STOP;
            S_CSUM_L: begin
              if (is_k)                             ev_err = E_UNEXP_K;
              else if ({csum_hi, byte_in} != ~sum)  ev_err = E_CSUM;
              else                                  ev_ok  = 1'b1;
            end
            default:  if (is_k) ev_err = E_UNEXP_K;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= 1'b0;
      idx       <= '0;
      seg       <= '0;
      sum       <= '0;
      csum_hi   <= '0;
      cseg      <= '0;
      c_word    <= '0;
      c_busy    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        stage[i] <= '0;
        cbuf[i]  <= '0;
      end
    end else begin
      frame_ok  <= ev_ok;
      frame_err <= (ev_err != E_NONE);
      if (ev_err != E_NONE) begin
        err_code <= ev_err;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
      if (ev_ok && ok_cnt != '1) ok_cnt <= ok_cnt + CNT_W'(1);

      phase <= ~phase;
      if (state == S_IDLE) begin
        if (aligned && is_start) begin
          state <= S_ADDR;
          phase <= 1'b0;
        end
      end else if (ev_err == E_RESTART) begin
        // The restarting K28.2 is itself the new frame's start: re-lock phase here
        state <= S_ADDR;
        phase <= 1'b0;
      end else if (ev_err != E_NONE) begin
        state <= S_IDLE;
      end else if (slot) begin
        case (state)
          S_ADDR: begin
            seg   <= byte_in;
            sum   <= {8'h00, byte_in};
            idx   <= '0;
            state <= S_DATA;
          end
          S_DATA: begin
            stage[idx] <= byte_in;
            sum        <= sum + {8'h00, byte_in};
            idx        <= idx + 4'd1;
            if (idx == 4'd15) state <= S_STOP;
          end
          S_STOP:   state <= S_CSUM_H;
          S_CSUM_H: begin
            csum_hi <= byte_in;
            state   <= S_CSUM_L;
          end
          default:  state <= S_IDLE;
        endcase
      end

      // Commit writer owns its own buffer so a new frame can parse underneath it
      if (ev_ok) begin
        for (int unsigned i = 0; i < 16; i++) cbuf[i] <= stage[i];
        cseg    <= seg;
        c_word  <= 2'd1;
        c_busy  <= 1'b1;
        wr_en   <= 1'b1;
        wr_addr <= {seg, 2'b00};
        wr_data <= {stage[0], stage[1], stage[2], stage[3]};
      end else if (c_busy) begin
        wr_en   <= 1'b1;
        wr_addr <= {cseg, c_word};
        wr_data <= c_word_data;
        c_word  <= c_word + 2'd1;
        if (c_word == 2'd3) c_busy <= 1'b0;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_segbuf_rx.sv
// Scoreboard bench for segbuf_rx: frames are judged by an array-level model,
// expected events/writes are queued and a negedge monitor compares them.
module tb_segbuf_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        aligned;
  logic [15:0] rx_data;
  logic [1:0]  rxcharisk;

  logic        wr_en, frame_ok, frame_err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;

  logic        s_wr_en, s_frame_ok, s_frame_err;
  logic [9:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_err_code;
  logic [1:0]  s_ok_cnt, s_err_cnt;

  always #5 clk = ~clk;

  segbuf_rx #(.INTERLEAVED(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .aligned(aligned), .rx_data(rx_data), .rxcharisk(rxcharisk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_ok(frame_ok),
    .frame_err(frame_err), .err_code(err_code), .ok_cnt(ok_cnt), .err_cnt(err_cnt));

  segbuf_rx #(.INTERLEAVED(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .aligned(aligned), .rx_data(rx_data), .rxcharisk(rxcharisk),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .frame_ok(s_frame_ok),
    .frame_err(s_frame_err), .err_code(s_err_code), .ok_cnt(s_ok_cnt), .err_cnt(s_err_cnt));

  typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic ok; logic [2:0] code; logic [15:0] okc; logic [15:0] errc; } ev_t;

  wr_t wrq[$];
  ev_t evq[$];

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned tot_ok = 0;
  int unsigned tot_err = 0;
  logic [2:0]  last_code = 3'd0;
  logic [8:0]  frm [21];   // {K, byte}: 0 start, 1 seg, 2..17 data, 18 stop, 19/20 csum

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int judge();
    logic [15:0] s;
    for (int i = 1; i <= 20; i++) begin
      if (frm[i] == {1'b1, 8'h5C}) return 4;
      if (i == 18) begin
        if (frm[i] != {1'b1, 8'h3C}) return 2;
      end else if (frm[i][8]) begin
        return 3;
      end
    end
    s = 16'h0000;
    for (int i = 1; i <= 17; i++) s = s + {8'h00, frm[i][7:0]};
    if ({frm[19][7:0], frm[20][7:0]} != 16'hFFFF - s) return 1;
    return 0;
  endfunction

  task automatic fix_csum();
    logic [15:0] s;
    s = 16'h0000;
    for (int i = 1; i <= 17; i++) s = s + {8'h00, frm[i][7:0]};
    s = 16'hFFFF - s;
    frm[19] = {1'b0, s[15:8]};
    frm[20] = {1'b0, s[7:0]};
  endtask

  task automatic make_frame(input logic [7:0] seg);
    frm[0] = {1'b1, 8'h5C};
    frm[1] = {1'b0, seg};
    for (int i = 2; i <= 17; i++) frm[i] = {1'b0, 8'($urandom)};
    frm[18] = {1'b1, 8'h3C};
    fix_csum();
  endtask

  task automatic expect_code(input int code);
    ev_t e;
    if (code == 0) begin
      tot_ok++;
      for (int w = 0; w < 4; w++)
        wrq.push_back('{a: {frm[1][7:0], 2'(w)},
                        d: {frm[2+4*w][7:0], frm[3+4*w][7:0], frm[4+4*w][7:0], frm[5+4*w][7:0]}});
      e.ok = 1'b1;
    end else begin
      tot_err++;
      last_code = 3'(code);
      e.ok = 1'b0;
    end
    e.code = last_code;
    e.okc  = 16'(tot_ok);
    e.errc = 16'(tot_err);
    evq.push_back(e);
  endtask

  task automatic tick(input logic [8:0] s, input logic al);
    @(posedge clk);
    #1;
    rx_data   = {8'($urandom), s[7:0]};
    rxcharisk = {1'($urandom), s[8]};
    aligned   = al;
  endtask

  task automatic filler(input logic al);
    tick({1'b0, 8'($urandom)}, al);
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      tick(frm[i], 1'b1);
      filler(1'b1);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a status pulse
  initial begin
    int pend = 0;
    wr_t w;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pend > 0) begin
          chk("wr_burst_contig", wr_en, 1);
          pend--;
        end
        if (wr_en) begin
          if (wr_addr[1:0] == 2'd0) pend = 3;
          chk("wr_expected", wrq.size() > 0, 1);
          if (wrq.size() > 0) begin
            w = wrq.pop_front();
            chk("wr_addr", wr_addr, w.a);
            chk("wr_data", wr_data, w.d);
          end
        end
        if (frame_ok || frame_err) begin
          chk("ok_err_exclusive", frame_ok & frame_err, 0);
          if (frame_ok) chk("ok_with_word0", {wr_en, wr_addr[1:0]}, 3'b100);
          chk("ev_expected", evq.size() > 0, 1);
          if (evq.size() > 0) begin
            e = evq.pop_front();
            chk("ev_is_ok", frame_ok, e.ok);
            chk("err_code", err_code, e.code);
            chk("ok_cnt", ok_cnt, e.okc);
            chk("err_cnt", err_cnt, e.errc);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] tp [16];
    logic [7:0] kset [7];
    int mode, pos, code, n;
    reset = 1'b1; aligned = 1'b1; rx_data = '0; rxcharisk = '0;
    kset = '{8'h1C, 8'h3C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pulses", {frame_ok, frame_err}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_ok_cnt", ok_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) filler(1'b1);

    // Reference frame: seg FF, checksum FCF0
    tp = '{8'h00, 8'h8B, 8'hFC, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h07,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
    make_frame(8'hFF);
    for (int i = 0; i < 16; i++) frm[2+i] = {1'b0, tp[i]};
    fix_csum();
    chk("model_ref_csum", {frm[19][7:0], frm[20][7:0]}, 16'hFCF0);
    expect_code(judge()); send(21); repeat (4) filler(1'b1);

    frm[20] = {1'b0, 8'hF1};
    expect_code(judge()); send(21); repeat (4) filler(1'b1);

    make_frame(8'h33); frm[18] = {1'b0, 8'h3C};
    expect_code(judge()); send(21);
    make_frame(8'h04);
    expect_code(judge()); send(21); repeat (4) filler(1'b1);

    // Restart at data idx 7 (position 9) with a complete new frame
    make_frame(8'h5A);
    expect_code(4); send(9);
    make_frame(8'hA5);
    expect_code(judge()); send(21); repeat (4) filler(1'b1);

    // aligned lost at data idx 3, then a start while unaligned in IDLE is ignored
    make_frame(8'h11);
    expect_code(5); send(5);
    tick(frm[5], 1'b0);
    repeat (3) filler(1'b0);
    tick({1'b1, 8'h5C}, 1'b0);
    repeat (6) filler(1'b0);
    repeat (2) filler(1'b1);

    // Back-to-back: second start lands at t_L+2
    make_frame(8'h21); expect_code(0); send(21);
    make_frame(8'h22); expect_code(0); send(21);
    repeat (4) filler(1'b1);

    for (int f = 0; f < 30; f++) begin
      make_frame(8'($urandom));
      mode = int'($urandom_range(0, 4));
      case (mode)
        1: begin pos = int'($urandom_range(1, 17)); frm[pos][$urandom_range(0, 7)] ^= 1'b1; end
        2: frm[18] = {1'b0, 8'h3C};
        3: begin
          pos = int'($urandom_range(1, 20));
          frm[pos] = {1'b1, kset[$urandom_range(0, 6)]};
        end
        default: ;
      endcase
      code = judge();
      expect_code(code);
      send(21);
      repeat ($urandom_range(0, 3)) filler(1'b1);
    end

    n = 0;
    while ((evq.size() > 0 || wrq.size() > 0) && n < 200) begin
      filler(1'b1);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("evq_drained", evq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    chk("sat_err_cnt", s_err_cnt, (tot_err > 3) ? 3 : tot_err);
    chk("sat_ok_cnt", s_ok_cnt, (tot_ok > 3) ? 3 : tot_ok);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
